program_encoder_loader: RTL and testbench

//  Encoder counterpart of the processor's instruction decode path. Accepts decoded instruction

---
 rtl/program_encoder_loader.sv | 142 ++++++++++++++
 tb/tb_program_encoder_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_encoder_loader.sv
// rtl/program_encoder_loader.sv - packs decoded RV32I fields into words and loads instruction memory
module program_encoder_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_class,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7_5,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [20:0]           in_imm,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_WIDTH:0]   COUNT_LAST = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    state_t             state, state_next;
    logic [31:0]        enc_word;
    logic               imm_ok;
    logic               we_raw;
    logic               fits_12;
    logic               fits_branch;
    logic [11:0]        i_imm;
    logic signed [20:0] simm;

    assign simm        = $signed(in_imm);
    assign fits_12     = (simm >= -21'sd2048) && (simm <= 21'sd2047);
    assign fits_branch = (simm >= -21'sd4096) && (simm <= 21'sd4094) && !in_imm[0];

    // Shift-immediate ops carry the arithmetic/logical select in imm[10].
    assign i_imm = (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                 ? {1'b0, in_funct7_5, 5'b00000, in_imm[4:0]}
                 : in_imm[11:0];

    always_comb begin
        enc_word = 32'h0;
        imm_ok   = 1'b0;
        case (in_class)
            3'd0: begin
                enc_word = {1'b0, in_funct7_5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
                imm_ok   = 1'b1;
            end
            3'd1: begin
                enc_word = {i_imm, in_rs1, in_funct3, in_rd, 7'b0010011};
                imm_ok   = fits_12;
            end
            3'd2: begin
                enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
                imm_ok   = fits_12;
            end
            3'd3: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
                imm_ok   = fits_12;
            end
            3'd4: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
                imm_ok   = fits_branch;
            end
            3'd5: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
                imm_ok   = !in_imm[0];
            end
            default: begin
                enc_word = 32'h0;
                imm_ok   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        we_raw     = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_class == 3'd6) begin
                        state_next = S_DONE;
                    end else if (!imm_ok) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                we_raw     = 1'b1;
                state_next = (count == COUNT_LAST) ? S_DONE : S_LOAD;
            end
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LOAD;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            count      <= '0;
        end else begin
            state <= state_next;
            if (state == S_LOAD && state_next == S_WRITE) begin
                imem_wdata <= enc_word;
            end
            if (state == S_WRITE) begin
                imem_addr <= imem_addr + ADDR_ONE;
                count     <= count + COUNT_ONE;
            end
        end
    end

    // Gating with reset guarantees no stray write while the loader is being reset.
    assign imem_we   = we_raw && !reset;
    assign cpu_reset = (state != S_DONE);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);

endmodule

// File: tb/tb_program_encoder_loader.sv
// tb/tb_program_encoder_loader.sv - scoreboard bench for program_encoder_loader
module tb_program_encoder_loader;

    localparam int AW    = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_class;
    logic [2:0]    in_funct3;
    logic          in_funct7_5;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [20:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [AW:0]   count;

    program_encoder_loader #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   wr_cycles[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    int m_cnt;
    bit m_done;
    bit m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from the RV32I field layouts using integer arithmetic.
    function automatic logic [32:0] ref_encode(input int cls, input int f3, input int f7,
                                               input int rd, input int rs1, input int rs2,
                                               input int iv);
        logic [31:0] w;
        logic [31:0] imf;
        bit ok;
        w  = 32'h0;
        ok = 1'b1;
        case (cls)
            0: w = (f7 != 0 ? 32'h4000_0000 : 32'h0) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            1: begin
                ok  = (iv >= -2048) && (iv <= 2047);
                imf = (f3 == 1 || f3 == 5) ? ((f7 != 0 ? 32'h400 : 32'h0) | (iv & 32'h1F)) : (iv & 32'hFFF);
                w   = (imf << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end
            2: begin
                ok = (iv >= -2048) && (iv <= 2047);
                w  = ((iv & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
            end
            3: begin
                ok = (iv >= -2048) && (iv <= 2047);
                w  = (((iv >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                   | ((iv & 32'h1F) << 7) | 32'h23;
            end
            4: begin
                ok = (iv >= -4096) && (iv <= 4094) && (iv % 2 == 0);
                w  = (((iv >> 12) & 1) << 31) | (((iv >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
                   | (f3 << 12) | (((iv >> 1) & 32'hF) << 8) | (((iv >> 11) & 1) << 7) | 32'h63;
            end
            5: begin
                ok = (iv % 2 == 0);
                w  = (((iv >> 20) & 1) << 31) | (((iv >> 1) & 32'h3FF) << 21) | (((iv >> 11) & 1) << 20)
                   | (((iv >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
            end
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0h, none expected", imem_addr, imem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), e.addr);
                check("write_data", imem_wdata, e.data);
            end
        end
    end

    task automatic model_clear();
        m_cnt  = 0;
        m_done = 0;
        m_err  = 0;
        exp_q.delete();
        wr_cycles.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic send(input int cls, input int f3, input int f7, input int rd, input int rs1,
                        input int rs2, input int iv, input bit use_exp = 0,
                        input logic [31:0] exp_word = 32'h0);
        logic [32:0] r;
        int t;
        exp_t e;
        r = ref_encode(cls, f3, f7, rd, rs1, rs2, iv);
        @(negedge clk);
        in_class    = 3'(cls);
        in_funct3   = 3'(f3);
        in_funct7_5 = 1'(f7);
        in_rd       = 5'(rd);
        in_rs1      = 5'(rs1);
        in_rs2      = 5'(rs2);
        in_imm      = 21'(iv);
        in_valid    = 1'b1;
        if (m_done || m_err) begin
            repeat (3) begin
                check("ignored_ready", 32'(in_ready), 0);
                @(negedge clk);
            end
            in_valid = 1'b0;
            return;
        end
        t = 0;
        while (!in_ready && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        if (cls == 6) begin
            m_done = 1;
        end else if (!r[32]) begin
            m_err = 1;
        end else begin
            e.addr = m_cnt;
            e.data = use_exp ? exp_word : r[31:0];
            exp_q.push_back(e);
            m_cnt++;
            if (m_cnt == DEPTH) m_done = 1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (cls <= 5 && r[32]) begin
            @(negedge clk);
            check("write_latency_we", 32'(imem_we), 1);
            check("write_cycle_ready", 32'(in_ready), 0);
        end
    endtask

    task automatic check_status();
        @(negedge clk);
        @(negedge clk);
        check("done", 32'(done), 32'(m_done));
        check("error", 32'(error), 32'(m_err));
        check("cpu_reset", 32'(cpu_reset), 32'(!m_done));
        check("in_ready", 32'(in_ready), 32'(!m_done && !m_err));
        check("count", 32'(count), m_cnt);
        check("pending_writes", exp_q.size(), 0);
    endtask

    function automatic int rand_imm();
        int bl[10] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4097, 3, -8};
        case ($urandom_range(0, 7))
            0: return int'($urandom_range(0, 64)) - 32;
            1: return bl[$urandom_range(0, 9)];
            2: return int'($urandom_range(0, 32'h1FFFFF)) - 32'h100000;
            default: return (int'($urandom_range(0, 4095)) - 2048) * 2;
        endcase
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_class = '0; in_funct3 = '0; in_funct7_5 = 1'b0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        model_clear();
        do_reset();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_cpu_reset", 32'(cpu_reset), 1);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_count", 32'(count), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);

        send(0, 0, 0, 3, 1, 2, 0, 1, 32'h002081B3);
        send(0, 0, 1, 5, 6, 7, 0, 1, 32'h407302B3);
        send(6, 0, 0, 0, 0, 0, 0);
        check_status();
        send(0, 0, 0, 1, 1, 1, 0);
        check_status();

        do_reset();
        send(4, 0, 0, 0, 1, 2, -8, 1, 32'hFE208CE3);
        send(5, 0, 0, 1, 0, 0, 16, 1, 32'h010000EF);
        check_status();

        do_reset();
        send(3, 0, 0, 0, 1, 2, 2048);
        check_status();
        do_reset();
        check("err_released", 32'(error), 0);
        send(4, 0, 0, 0, 1, 2, 3);
        check_status();
        do_reset();
        check("err_released2", 32'(error), 0);
        check("cpu_reset_held", 32'(cpu_reset), 1);

        do_reset();
        for (int i = 0; i < DEPTH; i++) send(0, i, 0, i + 1, i + 2, i + 3, 0);
        check_status();
        check("fill_writes", wr_cycles.size(), DEPTH);
        for (int i = 1; i < wr_cycles.size(); i++) check("write_spacing", wr_cycles[i] - wr_cycles[i-1], 2);
        send(0, 0, 0, 1, 1, 1, 0);

        do_reset();
        send(0, 0, 0, 9, 9, 9, 0);
        send(0, 0, 0, 4, 4, 4, 0);
        @(negedge clk);
        in_class = 3'd0; in_funct7_5 = 1'b0; in_rd = 5'd10; in_valid = 1'b1;
        check("pre_reset_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("we_gated_by_reset", 32'(imem_we), 0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        check("count_restart", 32'(count), 0);
        send(0, 0, 0, 11, 12, 13, 0);
        check_status();

        for (int p = 0; p < 25; p++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                int r;
                int cls;
                r   = $urandom_range(0, 15);
                cls = (r < 12) ? (r % 6) : ((r < 14) ? 6 : 7);
                send(cls, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), rand_imm());
            end
            check_status();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
